// File: rtl/rv_pkg.sv
// Core-wide register-file widths and the writeback request record.
// Pure declarations: no logic, no latency, no flow control.
// Imported by the writeback interface, arbiter and scoreboard.
package rv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/reg_writeback_if.sv
// Bundle of issue, ALU/load result, register-file write and hazard-query signals.
// Wiring only; timing is set by reg_writeback.
// Optional forwarding signals appear only when WB_BYPASS_EN is defined.
interface reg_writeback_if;
    import rv_pkg::*;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_ready;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_data;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
`ifdef WB_BYPASS_EN
    logic                  rs1_fwd;
    logic [XLEN-1:0]       rs1_fwd_data;
    logic                  rs2_fwd;
    logic [XLEN-1:0]       rs2_fwd_data;

    modport master (
        output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
               mem_valid, mem_rd, mem_data, rs1_addr, rs2_addr,
        input  issue_ready, alu_ready, mem_ready, RegWrite, rd_addr, rd_data,
               rs1_busy, rs2_busy, rs1_fwd, rs1_fwd_data, rs2_fwd, rs2_fwd_data
    );
    modport slave (
        input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
               mem_valid, mem_rd, mem_data, rs1_addr, rs2_addr,
        output issue_ready, alu_ready, mem_ready, RegWrite, rd_addr, rd_data,
               rs1_busy, rs2_busy, rs1_fwd, rs1_fwd_data, rs2_fwd, rs2_fwd_data
    );
`else
    modport master (
        output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
               mem_valid, mem_rd, mem_data, rs1_addr, rs2_addr,
        input  issue_ready, alu_ready, mem_ready, RegWrite, rd_addr, rd_data,
               rs1_busy, rs2_busy
    );
    modport slave (
        input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
               mem_valid, mem_rd, mem_data, rs1_addr, rs2_addr,
        output issue_ready, alu_ready, mem_ready, RegWrite, rd_addr, rd_data,
               rs1_busy, rs2_busy
    );
`endif
endinterface

// File: rtl/wb_scoreboard.sv
// Per-register in-flight write counters driving issue_ready and rs busy flags.
// Counters update on posedge; issue_ready/busy are combinational from current counts.
// Issue is refused while its destination counter is saturated; WB_BYPASS_EN adds forwarding.
module wb_scoreboard
    import rv_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
`ifdef WB_BYPASS_EN
    input  logic [XLEN-1:0]       wr_data,
    output logic                  rs1_fwd,
    output logic [XLEN-1:0]       rs1_fwd_data,
    output logic                  rs2_fwd,
    output logic [XLEN-1:0]       rs2_fwd_data,
`endif
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt [NUM_REGS];
    logic              issue_fire;
    logic              rs1_raw;
    logic              rs2_raw;

    assign issue_ready = (issue_rd == '0) | (cnt[issue_rd] != CNT_MAX);
    assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

    // Entry 0 is only ever reset, so x0 never reads as busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (issue_fire && issue_rd == REG_ADDR_W'(i) &&
                    !(wr_en && wr_addr == REG_ADDR_W'(i)))
                    cnt[i] <= cnt[i] + PEND_W'(1);
                else if (wr_en && wr_addr == REG_ADDR_W'(i) &&
                         !(issue_fire && issue_rd == REG_ADDR_W'(i)) && cnt[i] != '0)
                    cnt[i] <= cnt[i] - PEND_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && wr_en && wr_addr != '0 && cnt[wr_addr] == '0 &&
            !(issue_fire && issue_rd == wr_addr))
            $display("ERROR wb_scoreboard: retire to x%0d with no pending write", wr_addr);
    end
`endif

    assign rs1_raw = (rs1_addr != '0) & (cnt[rs1_addr] != '0);
    assign rs2_raw = (rs2_addr != '0) & (cnt[rs2_addr] != '0);

`ifdef WB_BYPASS_EN
    // A source whose last outstanding write is on the port this cycle can take it from the bypass.
    assign rs1_fwd      = wr_en & (wr_addr == rs1_addr) & (rs1_addr != '0);
    assign rs2_fwd      = wr_en & (wr_addr == rs2_addr) & (rs2_addr != '0);
    assign rs1_fwd_data = wr_data;
    assign rs2_fwd_data = wr_data;
    assign rs1_busy     = rs1_raw & ~(rs1_fwd & (cnt[rs1_addr] == PEND_W'(1)));
    assign rs2_busy     = rs2_raw & ~(rs2_fwd & (cnt[rs2_addr] == PEND_W'(1)));
`else
    assign rs1_busy = rs1_raw;
    assign rs2_busy = rs2_raw;
`endif
endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter (load priority, ALU anti-starvation) feeding the register-file write port.
// Accept at edge N -> RegWrite during cycle N+1; one grant per cycle, full write rate.
// Readies are combinational, zero in reset; optional WB_BYPASS_EN adds rs forwarding.
module reg_writeback
    import rv_pkg::*;
#(
    parameter int PEND_W     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    reg_writeback_if.slave  wb
);
    localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;
    logic                alu_win;
    logic                alu_fire;
    logic                mem_fire;
    wb_req_t             grant_req;

    assign alu_win      = wb.alu_valid & (~wb.mem_valid | (starve_cnt == STARVE_LIM));
    assign wb.alu_ready = alu_win & ~rst;
    assign wb.mem_ready = wb.mem_valid & ~alu_win & ~rst;
    assign alu_fire     = wb.alu_valid & wb.alu_ready;
    assign mem_fire     = wb.mem_valid & wb.mem_ready;

    always_comb begin
        grant_req = '{rd: wb.mem_rd, data: wb.mem_data};
        if (alu_fire) grant_req = '{rd: wb.alu_rd, data: wb.alu_data};
    end

    // A waiting ALU is granted as soon as the count reaches the limit, so it never passes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (wb.alu_valid && !wb.alu_ready)
            starve_cnt <= starve_cnt + STARVE_W'(1);
        else
            starve_cnt <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.RegWrite <= 1'b0;
            wb.rd_addr  <= '0;
            wb.rd_data  <= '0;
        end else if ((alu_fire || mem_fire) && grant_req.rd != '0) begin
            wb.RegWrite <= 1'b1;
            wb.rd_addr  <= grant_req.rd;
            wb.rd_data  <= grant_req.data;
        end else begin
            wb.RegWrite <= 1'b0;
        end
    end

    wb_scoreboard #(.PEND_W(PEND_W)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (wb.issue_valid),
        .issue_rd     (wb.issue_rd),
        .issue_ready  (wb.issue_ready),
        .wr_en        (wb.RegWrite),
        .wr_addr      (wb.rd_addr),
`ifdef WB_BYPASS_EN
        .wr_data      (wb.rd_data),
        .rs1_fwd      (wb.rs1_fwd),
        .rs1_fwd_data (wb.rs1_fwd_data),
        .rs2_fwd      (wb.rs2_fwd),
        .rs2_fwd_data (wb.rs2_fwd_data),
`endif
        .rs1_addr     (wb.rs1_addr),
        .rs2_addr     (wb.rs2_addr),
        .rs1_busy     (wb.rs1_busy),
        .rs2_busy     (wb.rs2_busy)
    );
endmodule

// File: tb/tb_reg_writeback.sv
// Randomized bench for reg_writeback: a behavioural model predicts readies, hazards and writes.
// Expected writes queue up at grant time; a monitor pops them whenever RegWrite is seen.
module tb_reg_writeback;
    localparam int PEND_MAX   = 3;
    localparam int STARVE_MAX = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    reg_writeback_if wb();

    reg_writeback #(.PEND_W(2), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: outstanding writes per register, results still owed per register,
    // the write on the port next cycle, and how long the ALU has been waiting.
    int          pend [32];
    int          owed [32];
    bit          wp_v;
    logic [4:0]  wp_a;
    logic [31:0] last_d;
    int          alu_wait;
    bit          last_win;
    wr_t         expq [$];

    bit          iv;
    logic [4:0]  ird, rs1, rs2;
    bit          a_act, m_act;
    logic [4:0]  a_rd, m_rd;
    logic [31:0] a_dat, m_dat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit exp_fwd(input logic [4:0] rs);
        return BYP && wp_v && (wp_a == rs) && (rs != 0);
    endfunction

    function automatic bit exp_busy(input logic [4:0] rs);
        return (rs != 0) && (pend[rs] != 0) && !(exp_fwd(rs) && pend[rs] == 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            pend[i] = 0;
            owed[i] = 0;
        end
        wp_v = 0; wp_a = 0; last_d = 0; alu_wait = 0;
        a_act = 0; m_act = 0; iv = 0;
        expq.delete();
    endtask

    task automatic make_req(output bit act, output logic [4:0] rd, output logic [31:0] d);
        int start;
        act = 0; rd = 0; d = $urandom;
        if ($urandom_range(0, 7) == 0) begin
            act = 1;
            return;
        end
        start = $urandom_range(0, 6);
        for (int k = 0; k < 7; k++) begin
            int r;
            r = 1 + (start + k) % 7;
            if (owed[r] > 0) begin
                owed[r]--;
                act = 1;
                rd  = 5'(r);
                return;
            end
        end
    endtask

    task automatic run_cycle();
        bit  exp_ir, win, alu_waiting, granted;
        wr_t g;
        @(negedge clk);
        wb.issue_valid = iv;    wb.issue_rd = ird;
        wb.rs1_addr    = rs1;   wb.rs2_addr = rs2;
        wb.alu_valid   = a_act; wb.alu_rd   = a_rd; wb.alu_data = a_dat;
        wb.mem_valid   = m_act; wb.mem_rd   = m_rd; wb.mem_data = m_dat;
        #1;
        exp_ir = (ird == 0) || (pend[ird] < PEND_MAX);
        win    = a_act && (!m_act || alu_wait == STARVE_MAX);
        chk("issue_ready", wb.issue_ready, exp_ir);
        chk("alu_ready", wb.alu_ready, win);
        chk("mem_ready", wb.mem_ready, m_act && !win);
        chk("rs1_busy", wb.rs1_busy, exp_busy(rs1));
        chk("rs2_busy", wb.rs2_busy, exp_busy(rs2));
`ifdef WB_BYPASS_EN
        chk("rs1_fwd", wb.rs1_fwd, exp_fwd(rs1));
        chk("rs2_fwd", wb.rs2_fwd, exp_fwd(rs2));
        chk("rs1_fwd_data", wb.rs1_fwd_data, last_d);
        chk("rs2_fwd_data", wb.rs2_fwd_data, last_d);
`endif
        last_win    = win;
        alu_waiting = a_act && !win;
        granted     = 0;
        g.a = 0; g.d = 0;
        if (win) begin
            g.a = a_rd; g.d = a_dat; granted = 1; a_act = 0;
        end else if (m_act) begin
            g.a = m_rd; g.d = m_dat; granted = 1; m_act = 0;
        end
        alu_wait = alu_waiting ? alu_wait + 1 : 0;
        if (iv && exp_ir && ird != 0) begin
            pend[ird]++;
            owed[ird]++;
        end
        if (wp_v) pend[wp_a]--;
        wp_v = granted && (g.a != 0);
        if (wp_v) begin
            wp_a   = g.a;
            last_d = g.d;
            expq.push_back(g);
        end
        @(posedge clk);
    endtask

    // Monitor: every observed write must be the oldest predicted one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && wb.RegWrite === 1'b1) begin
                chk("write_was_predicted", (expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("rd_addr", wb.rd_addr, e.a);
                    chk("rd_data", wb.rd_data, e.d);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        ird = 0; rs1 = 0; rs2 = 0; a_rd = 0; m_rd = 0; a_dat = 0; m_dat = 0;
        wb.issue_valid = 0; wb.issue_rd = 0; wb.rs1_addr = 0; wb.rs2_addr = 0;
        wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_data = 0;
        wb.mem_valid = 0; wb.mem_rd = 0; wb.mem_data = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // Reset state.
        wb.issue_rd = 5; wb.rs1_addr = 7;
        #1;
        chk("reset_RegWrite", wb.RegWrite, 0);
        chk("reset_rd_addr", wb.rd_addr, 0);
        chk("reset_rd_data", wb.rd_data, 0);
        chk("reset_rs1_busy", wb.rs1_busy, 0);
        chk("reset_issue_ready", wb.issue_ready, 1);

        // Issue x7, ALU result to x7, observe busy drop two edges later.
        iv = 1; ird = 7; rs1 = 7; rs2 = 0;
        run_cycle();
        iv = 0; owed[7]--; a_act = 1; a_rd = 7; a_dat = 32'h1234;
        repeat (3) run_cycle();

        // Saturate x3, retire one, then issue again.
        iv = 1; ird = 3; rs1 = 3; rs2 = 3;
        repeat (4) run_cycle();
        iv = 0; owed[3]--; m_act = 1; m_rd = 3; m_dat = 32'hCAFE0003;
        run_cycle();
        iv = 1;
        repeat (3) run_cycle();

        // Grant to x0 is dropped.
        iv = 0; a_act = 1; a_rd = 0; a_dat = 32'hFFFF;
        repeat (2) run_cycle();

        // Both sources held valid: four loads then one ALU, repeating.
        run_cycle();
        for (int i = 0; i < 15; i++) begin
            if (!a_act) begin a_act = 1; a_rd = 0; a_dat = $urandom; end
            if (!m_act) begin m_act = 1; m_rd = 0; m_dat = $urandom; end
            run_cycle();
            chk("starve_pattern", last_win, (i % 5) == 4);
        end
        a_act = 0; m_act = 0;
        run_cycle();

        // Write x9 and read it as rs2 the following cycle.
        iv = 1; ird = 9; rs1 = 0; rs2 = 9;
        run_cycle();
        iv = 0; owed[9]--; a_act = 1; a_rd = 9; a_dat = 32'hABCD;
        repeat (3) run_cycle();

        // Reset while a write is on the port.
        iv = 1; ird = 7; rs1 = 7;
        run_cycle();
        iv = 0; owed[7]--; a_act = 1; a_rd = 7; a_dat = 32'h5555;
        run_cycle();
        #2;
        chk("pre_rst_RegWrite", wb.RegWrite, 1);
        rst = 1;
        #1;
        chk("rst_RegWrite", wb.RegWrite, 0);
        chk("rst_rd_addr", wb.rd_addr, 0);
        chk("rst_rs1_busy", wb.rs1_busy, 0);
        wb.alu_valid = 1; wb.mem_valid = 1;
        #1;
        chk("rst_alu_ready", wb.alu_ready, 0);
        chk("rst_mem_ready", wb.mem_ready, 0);
        model_reset();
        wb.alu_valid = 0; wb.mem_valid = 0; wb.issue_valid = 0;
        @(negedge clk);
        #2;
        rst = 0;

        // Random traffic on a small register window to provoke hazards and saturation.
        for (int c = 0; c < 600; c++) begin
            iv  = $urandom_range(0, 1);
            ird = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            if (!a_act && $urandom_range(0, 2) != 0) make_req(a_act, a_rd, a_dat);
            if (!m_act && $urandom_range(0, 2) != 0) make_req(m_act, m_rd, m_dat);
            run_cycle();
        end

        iv = 0; a_act = 0; m_act = 0;
        repeat (4) run_cycle();
        chk("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
